// File: rtl/up_counter.sv
// up_counter: modulo-(MAX+1) up counter with synchronous clear, clamped
// parallel load, count enable, combinational terminal count (tc) for
// cascading, and a registered one-cycle wrap pulse after each rollover.
//
// Build option: define UP_COUNTER_SAT_EN to make the counter saturate at MAX
// instead of rolling over. In that build, wrap never asserts.
module up_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX);

    logic [WIDTH:0]   incr;
    logic             below_max;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    // Out-of-range load values are pinned to MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if ({1'b0, v} > MAX_EXT)
            return MAX_V;
        return v;
    endfunction

    // The increment is one bit wider than the counter, so the comparison
    // stays correct when MAX = 2^WIDTH-1.
    assign incr      = {1'b0, counter} + (WIDTH + 1)'(1);
    assign below_max = (incr <= MAX_EXT);

    // Terminal count is combinational, so a cascaded stage advances on the
    // same edge where this stage rolls over.
    assign tc = en && (counter == MAX_V);

    // Next-state selection in priority order: clear, load, count, hold.
    always_comb begin
        next_count = counter;
        next_wrap  = 1'b0;
        if (clr) begin
            next_count = '0;
        end else if (load) begin
            next_count = clamp_load(din);
        end else if (en) begin
            if (below_max) begin
                next_count = incr[WIDTH-1:0];
            end else begin
`ifdef UP_COUNTER_SAT_EN
                next_count = MAX_V;
`else
                next_count = '0;
                next_wrap  = 1'b1;
`endif
            end
        end
    end

    // Register the count and wrap pulse. Reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else begin
            counter <= next_count;
            wrap    <= next_wrap;
        end
    end

endmodule
